// File: rtl/div_19x19_seq.sv
// Sequential restoring divider, signed or unsigned, one quotient bit per cycle.
//
// Ports:
//   clk    - single clock, all state updates on the rising edge
//   reset  - synchronous active-high reset
//   start  - begin a division (sampled only while idle)
//   sign   - 1: two's-complement operands, 0: unsigned (captured with start)
//   A, B   - dividend / divisor (captured with start)
//   Q, R   - registered quotient / remainder, valid from done
//   busy   - high while the division is in progress (CALC and FIX)
//   done   - one-cycle completion pulse
//   dbz    - divide-by-zero flag of the last completed division
//
// Timing: start accepted at cycle T, WIDTH iterations at T+1..T+WIDTH, sign
// fix-up at T+WIDTH+1, done at T+WIDTH+2.
module div_19x19_seq #(
  parameter int unsigned WIDTH = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  rem_q;     // partial remainder
  logic [WIDTH-1:0]  quo_q;     // dividend shifts out the top, quotient bits shift in
  logic [WIDTH-1:0]  div_q;     // |B|
  logic [WIDTH-1:0]  a_raw_q;   // original A, returned as R on divide-by-zero
  logic              sgn_q;
  logic              a_neg_q;
  logic              b_neg_q;
  logic              b_zero_q;

  logic [WIDTH-1:0]  a_abs;
  logic [WIDTH-1:0]  b_abs;
  logic [WIDTH:0]    trial;
  logic [WIDTH:0]    diff;
  logic              ge;
  logic [WIDTH-1:0]  rem_next;
  logic [WIDTH-1:0]  q_fix;
  logic [WIDTH-1:0]  r_fix;

  always_comb begin
    a_abs = (sign && A[WIDTH-1]) ? (~A + 1'b1) : A;
    b_abs = (sign && B[WIDTH-1]) ? (~B + 1'b1) : B;

    // Trial value is one bit wider: 2*rem+1 can exceed WIDTH bits.
    trial    = {rem_q, quo_q[WIDTH-1]};
    diff     = trial - {1'b0, div_q};
    ge       = (trial >= {1'b0, div_q});
    rem_next = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

    q_fix = (sgn_q && (a_neg_q ^ b_neg_q)) ? (~quo_q + 1'b1) : quo_q;
    r_fix = (sgn_q && a_neg_q) ? (~rem_q + 1'b1) : rem_q;
    if (b_zero_q) begin
      q_fix = '1;
      r_fix = a_raw_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      a_raw_q  <= '0;
      sgn_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      Q        <= '0;
      R        <= '0;
      dbz      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            sgn_q    <= sign;
            a_neg_q  <= sign & A[WIDTH-1];
            b_neg_q  <= sign & B[WIDTH-1];
            b_zero_q <= (B == '0);
            a_raw_q  <= A;
            div_q    <= b_abs;
            quo_q    <= a_abs;
            rem_q    <= '0;
            cnt_q    <= CntW'(WIDTH - 1);
            busy     <= 1'b1;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[WIDTH-2:0], ge};
          if (cnt_q == '0) begin
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StFix: begin
          Q       <= q_fix;
          R       <= r_fix;
          dbz     <= b_zero_q;
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_19x19_seq.sv
module tb_div_19x19_seq;

  localparam int unsigned W = 19;

  logic         clk;
  logic         reset;
  logic         start;
  logic         sign;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         busy;
  logic         done;
  logic         dbz;

  int errors = 0;
  int checks = 0;

  div_19x19_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .sign (sign),
    .A    (A),
    .B    (B),
    .Q    (Q),
    .R    (R),
    .busy (busy),
    .done (done),
    .dbz  (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one division and check busy/done every cycle up to the done pulse.
  // Returns at the negedge of the done cycle (T+21). With inject set, a second
  // start with other operands is driven during cycle T+5.
  task automatic run_div(input string tag, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eq,
                         input logic [W-1:0] er, input logic ed, input logic inject);
    @(negedge clk);
    start = 1'b1;
    sign  = s;
    A     = a;
    B     = b;
    @(posedge clk);
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (inject && k == 5) begin
        start = 1'b1;
        sign  = 1'b0;
        A     = 19'd77;
        B     = 19'd5;
      end else begin
        start = 1'b0;
      end
      check({tag, " busy"}, {31'd0, busy}, 32'd1);
      check({tag, " done early"}, {31'd0, done}, 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
    check({tag, " Q"}, {13'd0, Q}, {13'd0, eq});
    check({tag, " R"}, {13'd0, R}, {13'd0, er});
    check({tag, " dbz"}, {31'd0, dbz}, {31'd0, ed});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    sign  = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset Q", {13'd0, Q}, 32'd0);
    check("reset R", {13'd0, R}, 32'd0);
    check("reset dbz", {31'd0, dbz}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    run_div("u100/7", 1'b0, 19'd100, 19'd7, 19'd14, 19'd2, 1'b0, 1'b0);
    // Done must drop after one cycle and Q must hold.
    @(negedge clk);
    check("done pulse width", {31'd0, done}, 32'd0);
    check("Q hold", {13'd0, Q}, 32'd14);

    run_div("s-100/7", 1'b1, 19'h7FF9C, 19'd7, 19'h7FFF2, 19'h7FFFE, 1'b0, 1'b0);
    run_div("s100/-7", 1'b1, 19'd100, 19'h7FFF9, 19'h7FFF2, 19'd2, 1'b0, 1'b0);
    run_div("s-7/-2", 1'b1, 19'h7FFF9, 19'h7FFFE, 19'd3, 19'h7FFFF, 1'b0, 1'b0);
    run_div("u12345/0", 1'b0, 19'd12345, 19'd0, 19'h7FFFF, 19'd12345, 1'b1, 1'b0);
    run_div("u9/3", 1'b0, 19'd9, 19'd3, 19'd3, 19'd0, 1'b0, 1'b0);
    run_div("s-5/0", 1'b1, 19'h7FFFB, 19'd0, 19'h7FFFF, 19'h7FFFB, 1'b1, 1'b0);
    run_div("s ovf", 1'b1, 19'h40000, 19'h7FFFF, 19'h40000, 19'd0, 1'b0, 1'b0);
    run_div("umax/1", 1'b0, 19'h7FFFF, 19'd1, 19'h7FFFF, 19'd0, 1'b0, 1'b0);
    run_div("umax/max", 1'b0, 19'h7FFFF, 19'h7FFFF, 19'd1, 19'd0, 1'b0, 1'b0);
    run_div("u5/9", 1'b0, 19'd5, 19'd9, 19'd0, 19'd5, 1'b0, 1'b0);

    // Start at T+5 ignored; new start in the cycle after done accepted.
    run_div("proto first", 1'b0, 19'd1000, 19'd10, 19'd100, 19'd0, 1'b0, 1'b1);
    run_div("proto b2b", 1'b0, 19'd50, 19'd7, 19'd7, 19'd1, 1'b0, 1'b0);

    // Reset at T+10 aborts the division.
    @(negedge clk);
    start = 1'b1;
    sign  = 1'b0;
    A     = 19'd200;
    B     = 19'd3;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort Q", {13'd0, Q}, 32'd0);
    check("abort R", {13'd0, R}, 32'd0);
    check("abort dbz", {31'd0, dbz}, 32'd0);
    begin
      int seen = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (done) seen++;
      end
      check("no done after abort", seen, 32'd0);
    end

    // Reset and start together: start discarded.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    A     = 19'd8;
    B     = 19'd2;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("reset prio busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset prio idle", {31'd0, busy}, 32'd0);

    // Block still works after reset.
    run_div("post-reset 8/2", 1'b0, 19'd8, 19'd2, 19'd4, 19'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_19x19_seq.md
DIV_19X19_SEQ -- requirements
Module: div_19x19_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 19, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port sign  input  1  1 = two's-complement signed operands, 0 = unsigned; captured with start.
REQ-006 SHALL have port A  input  WIDTH  dividend; captured with start.
REQ-007 SHALL have port B  input  WIDTH  divisor; captured with start.
REQ-008 SHALL have port Q  output  WIDTH  quotient, registered.
REQ-009 SHALL have port R  output  WIDTH  remainder, registered.
REQ-010 SHALL have port busy  output  1  high from the cycle after start acceptance until done.
REQ-011 SHALL have port done  output  1  single-cycle pulse; Q/R/dbz valid from this cycle.
REQ-012 SHALL have port dbz  output  1  divide-by-zero flag for the last completed division.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-014 SHALL, in IDLE with start=1 (cycle T):
- capture sign, |A|, |B|, sign of A and sign of B;
- load iteration counter with WIDTH-1;
- enter CALC.
REQ-015 SHALL perform one restoring shift-subtract step per cycle in CALC, for exactly WIDTH cycles (T+1..T+WIDTH), then enter FIX.
REQ-016 SHALL, in FIX (cycle T+WIDTH+1), apply sign correction and register Q, R and dbz, then enter DONE.
REQ-017 SHALL assert done=1 for exactly one cycle, T+WIDTH+2 (T+21 at default), in DONE, then return to IDLE.
REQ-018 SHALL assert busy=1 in CALC and FIX only; busy SHALL be 0 in IDLE and DONE.
REQ-019 SHALL ignore start whenever the block is not in IDLE (including during DONE); operands SHALL NOT be recaptured.
REQ-020 SHALL hold Q, R and dbz stable from done until the FIX cycle of the next division.
REQ-021 SHALL, with sign=0, produce Q = floor(A/B) and R = A - Q*B (unsigned).
REQ-022 SHALL, with sign=1:
- truncate the quotient toward zero;
- negate Q iff the operand signs differ;
- give R the sign of A, with |R| < |B|.
REQ-023 SHALL, with sign=1, A=-2^(WIDTH-1) and B=-1, return Q = 2^(WIDTH-1) wrapped to WIDTH bits (0x40000) and R=0, with dbz=0.
REQ-024 SHALL, for B=0 (either mode):
- return Q = all ones (0x7FFFF) and R = A unmodified;
- set dbz=1;
- keep the normal latency (done at T+21).
REQ-025 SHALL clear dbz to 0 on every division with B≠0.
REQ-026 SHALL accept a new start in the cycle immediately after done (back-to-back throughput of one result per WIDTH+3 cycles).

Reset
REQ-027 SHALL, when reset=1 at a rising edge:
- enter IDLE;
- clear Q, R, dbz, busy, done and the iteration counter to 0.
REQ-028 SHALL honour reset mid-operation (CALC/FIX/DONE) with no done pulse for the aborted division.
REQ-029 SHALL give reset priority over start in the same cycle; the start is discarded.

Verification
REQ-030 Unsigned: sign=0, A=100, B=7, start at T -> busy=1 at T+1..T+20, done=1 only at T+21, Q=14, R=2, dbz=0.
REQ-031 Signed: sign=1, A=-100 (0x7FF9C), B=7 -> Q=0x7FFF2 (-14), R=0x7FFFE (-2); also A=100, B=-7 -> Q=-14, R=+2.
REQ-032 Divide by zero: sign=0, A=12345, B=0 -> done at T+21, Q=0x7FFFF, R=12345, dbz=1; a following 9/3 -> Q=3, R=0, dbz=0.
REQ-033 Signed overflow: sign=1, A=0x40000, B=0x7FFFF (-1) -> Q=0x40000, R=0, dbz=0.
REQ-034 Protocol: second start at T+5 with different operands -> ignored, first result returned at T+21; a new start at T+22 -> accepted, done at T+43.
REQ-035 Reset: reset=1 at T+10 of an active division -> next cycle busy=0, done=0, Q=R=0, dbz=0, and no done pulse follows.
